// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command sequencer.
// The frame timer width is derived from TIMEOUT so the counter holds TIMEOUT-1 exactly.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_TX_SEND
  } state_e;

  localparam int         DATA_W_DEF  = 8;
  localparam int         ADDR_W_DEF  = 4;
  localparam logic [7:0] CMD_WR_DEF  = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF  = 8'hBB;
  localparam int         TIMEOUT_DEF = 4096;

  function automatic int tmr_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  localparam int TMR_W = tmr_w(TIMEOUT_DEF);

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: cleared by start, counts while enabled,
// flags expiry once the count has reached TIMEOUT-1.
module uart_frame_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic expired
);

  localparam int            CW   = tmr_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is not gated by start: an accepted byte in the same cycle is
  // given priority inside the FSM instead, which avoids a combinational loop.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the UART receiver: parses write/read frames,
// drives the register-file port and returns read data to the transmitter.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] CMD_WR  = DATA_W'(CMD_WR_DEF),
  parameter logic [DATA_W-1:0] CMD_RD  = DATA_W'(CMD_RD_DEF),
  parameter int                TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              frame_err,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic rx_accept, addr_ok;
  logic timer_start, timer_en, timer_expired;

  assign rx_accept = rx_valid && !rx_err;
  assign addr_ok   = (rx_data[DATA_W-1:ADDR_W] == '0);

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_err) begin
          frame_err_d = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == CMD_WR)      state_d = ST_WR_ADDR;
          else if (rx_data == CMD_RD) state_d = ST_RD_ADDR;
          else                        frame_err_d = 1'b1;
        end
      end
      ST_WR_ADDR, ST_RD_ADDR: begin
        if (rx_err || (rx_accept && !addr_ok)) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (rx_accept) begin
          rf_addr_d = rx_data[ADDR_W-1:0];
          if (state_q == ST_WR_ADDR) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d    = ST_RD_WAIT;
            rf_rd_en_d = 1'b1;
          end
        end else if (timer_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (rx_err || (!rx_accept && timer_expired)) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (rx_accept) begin
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        // Any RX traffic here is an overrun; the read itself carries on.
        if (rx_valid || rx_err) frame_err_d = 1'b1;
        if (rf_rd_valid) begin
          tx_data_d  = rf_rd_data;
          tx_valid_d = 1'b1;
          state_d    = ST_TX_SEND;
        end else if (timer_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_TX_SEND: begin
        if (rx_valid || rx_err) frame_err_d = 1'b1;
        if (tx_valid_q && !tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_comb begin
    timer_en    = state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT};
    timer_start = (state_d != state_q) || rx_accept;
  end

  uart_frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer behind the UART receiver.
- Consumes validated bytes from the RX path and parses fixed-format command frames: write = CMD_WR, addr, data; read = CMD_RD, addr.
- Drives the register-file write/read port.
- Hands read-back data to the UART transmitter with a valid/busy handshake.
- Owns frame-level error handling: line errors, bad opcodes, bad addresses, inter-byte timeout and overrun.

Parameters:
DATA_W, 8, byte width of RX/TX/register data
ADDR_W, 4, register-file address width (ADDR_W < DATA_W)
CMD_WR, 8'hAA, write-command opcode
CMD_RD, 8'hBB, read-command opcode
TIMEOUT, 4096, max clk cycles allowed between bytes of one frame, or in RD_WAIT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx_data  in  DATA_W  received byte, valid with rx_valid
rx_valid  in  1  one-cycle pulse: byte received without error
rx_err  in  1  one-cycle pulse: frame received with parity or stop error
rf_addr  out  ADDR_W  register-file address
rf_wr_data  out  DATA_W  register-file write data
rf_wr_en  out  1  one-cycle write strobe
rf_rd_en  out  1  one-cycle read strobe
rf_rd_data  in  DATA_W  read data, valid with rf_rd_valid
rf_rd_valid  in  1  one-cycle read-data-valid pulse
tx_data  out  DATA_W  byte to transmit
tx_valid  out  1  transmit request, held until accepted
tx_busy  in  1  transmitter busy; byte accepted on tx_valid && !tx_busy
frame_err  out  1  one-cycle pulse per discarded frame
err_cnt  out  8  saturating count of frame_err pulses
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst).
- Reset values:
  - State = IDLE.
  - All strobes, tx_valid and frame_err = 0.
  - rf_addr, rf_wr_data, tx_data and err_cnt = 0.
  - Reset mid-frame aborts the frame; no strobe is issued.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND. Encoding lives in the package.
- IDLE:
  - rx_valid with rx_data==CMD_WR -> WR_ADDR.
  - rx_valid with rx_data==CMD_RD -> RD_ADDR.
  - rx_valid with any other byte -> frame_err, stay IDLE.
- WR_ADDR / RD_ADDR, on rx_valid:
  - If rx_data[DATA_W-1:ADDR_W] != 0 -> frame_err, IDLE.
  - Otherwise latch rf_addr.
  - WR_ADDR -> WR_DATA.
  - RD_ADDR -> RD_WAIT, with rf_rd_en pulsed in the cycle after the accepted rx_valid.
- WR_DATA, on rx_valid: latch rf_wr_data, pulse rf_wr_en the next cycle (rf_addr stable), -> IDLE.
- RD_WAIT, on rf_rd_valid: latch tx_data = rf_rd_data, assert tx_valid the next cycle, -> TX_SEND.
- TX_SEND:
  - tx_valid and tx_data held stable while tx_busy=1.
  - In the cycle where tx_valid && !tx_busy, the byte is accepted. tx_valid drops the next cycle; state -> IDLE.
  - No timeout applies in TX_SEND.
- rx_err:
  - In any state other than RD_WAIT/TX_SEND: frame_err, -> IDLE, latched fields untouched.
  - In IDLE: frame_err only.
- Overrun: rx_valid or rx_err during RD_WAIT/TX_SEND -> byte dropped, frame_err pulsed, state unaffected.
- Timeout:
  - A cycle counter runs in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - It clears on state entry and on every accepted rx_valid.
  - Reaching TIMEOUT-1 -> frame_err, IDLE, no strobe issued.
- Simultaneous events:
  - rx_valid and rx_err in the same cycle: treat as rx_err.
  - rx_valid on the same cycle as the timeout: the byte wins and the counter clears.
- frame_err is registered: it pulses one cycle after the triggering event.
- err_cnt increments on each frame_err and saturates at 255; it never wraps.
- rf_wr_en and rf_rd_en are never asserted in the same cycle.

Decomposition:
- Package uart_cmd_pkg holds:
  - state typedef/localparams;
  - default opcode constants;
  - TIMEOUT counter width, derived as clog2(TIMEOUT).
- One sub-module, uart_frame_timer:
  - load/clear on start, enable, expired flag;
  - parameterised by TIMEOUT.

Test Plan:
- Write: bytes AA,03,5C with ~100 idle cycles between them -> one rf_wr_en pulse with rf_addr=3, rf_wr_data=5C; busy low afterwards; err_cnt=0.
- Read with backpressure: BB,07; rf_rd_valid with rf_rd_data=C3 three cycles after rf_rd_en; tx_busy=1 for 50 cycles -> tx_valid held with tx_data=C3 throughout, dropped one cycle after tx_busy falls; state IDLE.
- Bad opcode and bad address: byte 12 in IDLE -> frame_err; AA,13 -> frame_err and no rf_wr_en; err_cnt=2.
- Timeout: AA,03, then silence for TIMEOUT cycles -> frame_err exactly at expiry; a later 5C is treated as a bad opcode (second frame_err).
- Line error and overrun: AA then rx_err -> frame_err, IDLE. During RD_WAIT, rx_valid=77 -> frame_err, read still completes with the correct tx_data.
- Saturation and reset: 300 bad-opcode bytes -> err_cnt=255. Then rst low for 1 cycle mid-write frame -> err_cnt=0, no rf_wr_en, IDLE.
